// File: rtl/mu0_run_ctrl.sv
// mu0_run_ctrl: run controller for the MU0 core.
// Turns debugger start/step/clock-mode commands into a registered core clock
// level plus a one-cycle tick strobe. Halts on core done or on a PC
// breakpoint, and hands the shared program memory to the UART debugger with
// the core clock frozen low.
module mu0_run_ctrl #(
    parameter int SLOW_DIV = 6318000,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [3:0]        clkMode,
    input  logic              startToggle,
    input  logic              stepReq,
    input  logic              done,
    input  logic [ADDR_W-1:0] pc,
    input  logic              bpEn,
    input  logic [ADDR_W-1:0] bpAddr,
    input  logic              dbgReq,
    output logic              dbgGnt,
    output logic              cpuClk,
    output logic              cpuTick,
    output logic              running,
    output logic [1:0]        haltCause
);

    // Slow counter only has to reach SLOW_DIV.
    localparam int CNT_W = (SLOW_DIV > 0) ? $clog2(SLOW_DIV + 1) : 1;

    localparam logic [3:0] MODE_FAST  = 4'd1;
    localparam logic [3:0] MODE_SLOW  = 4'd2;
    localparam logic [3:0] MODE_MAN_L = 4'd3;
    localparam logic [3:0] MODE_MAN_H = 4'd4;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_DONE = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        HALTED,
        DBG
    } state_t;

    state_t             state, stateD;
    state_t             retState, retStateD;   // where DBG / STEP return to
    logic               cpuClkD;
    logic               cpuTickD;
    logic               dbgGntD;
    logic [1:0]         haltCauseD;
    logic [CNT_W-1:0]   slowCnt, slowCntD;
    logic               bpSkip, bpSkipD;       // lets the first rise after a start pass a breakpoint
    logic               startQ;                // registered copy of startToggle
    logic [3:0]         modeQ;                 // previous clkMode, for change detection

    logic               startEv;
    logic               modeChg;
    logic               modeClk;               // clock level the mode rule asks for
    logic [CNT_W-1:0]   modeCnt;               // slow counter value the mode rule asks for
    logic               riseDue;
    logic               bpHit;

    assign startEv = (startToggle != startQ);
    assign modeChg = (clkMode != modeQ);
    assign bpHit   = bpEn && (pc == bpAddr) && !bpSkip;
    assign riseDue = !cpuClk && modeClk;
    assign running = (state == RUN);

    // Mode rule: the clock level and counter value a free run would produce.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        modeClk = 1'b0;
        modeCnt = '0;
        case (clkMode)
            MODE_FAST: begin
                modeClk = !cpuClk;
            end
            MODE_SLOW: begin
                modeClk = cpuClk;
                if (modeChg) begin
                    modeCnt = '0;
                end else if (slowCnt == CNT_W'(SLOW_DIV)) begin
                    modeClk = !cpuClk;
                    modeCnt = '0;
                end else begin
                    modeCnt = slowCnt + 1'b1;
                end
            end
            MODE_MAN_L: modeClk = 1'b0;
            MODE_MAN_H: modeClk = 1'b1;
            default:    modeClk = 1'b0;   // off, and any unknown mode
        endcase
    end

    // Next-state and next-output logic of the run controller.
    always_comb begin
        stateD     = state;
        retStateD  = retState;
        cpuClkD    = cpuClk;
        cpuTickD   = 1'b0;
        dbgGntD    = dbgGnt;
        haltCauseD = haltCause;
        slowCntD   = slowCnt;
        bpSkipD    = bpSkip;

        case (state)
            IDLE, HALTED: begin
                cpuClkD  = 1'b0;
                slowCntD = '0;
                if (startEv) begin
                    stateD     = RUN;
                    haltCauseD = CAUSE_NONE;
                    bpSkipD    = 1'b1;
                end else if (stepReq) begin
                    stateD    = STEP;
                    retStateD = state;
                    cpuClkD   = 1'b1;
                    cpuTickD  = 1'b1;
                end else if (dbgReq) begin
                    stateD    = DBG;
                    retStateD = state;
                    dbgGntD   = 1'b1;
                end
            end

            RUN: begin
                if (done) begin
                    stateD     = HALTED;
                    haltCauseD = CAUSE_DONE;
                    cpuClkD    = 1'b0;
                end else if (dbgReq) begin
                    // Bring the clock low first; grant only once it is low.
                    cpuClkD = 1'b0;
                    if (!cpuClk) begin
                        stateD    = DBG;
                        retStateD = RUN;
                        dbgGntD   = 1'b1;
                    end
                end else if (riseDue && bpHit) begin
                    stateD     = HALTED;
                    haltCauseD = CAUSE_BP;
                end else begin
                    cpuClkD  = modeClk;
                    slowCntD = modeCnt;
                    if (riseDue) begin
                        cpuTickD = 1'b1;
                        bpSkipD  = 1'b0;
                    end
                end
            end

            STEP: begin
                // One high cycle was issued on entry; drop and go back.
                cpuClkD = 1'b0;
                stateD  = retState;
            end

            DBG: begin
                cpuClkD = 1'b0;
                if (done) begin
                    retStateD  = HALTED;
                    haltCauseD = CAUSE_DONE;
                end
                if (!dbgReq) begin
                    dbgGntD  = 1'b0;
                    stateD   = retStateD;
                    slowCntD = '0;
                end
            end

            default: begin
                stateD  = IDLE;
                cpuClkD = 1'b0;
                dbgGntD = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            retState  <= IDLE;
            cpuClk    <= 1'b0;
            cpuTick   <= 1'b0;
            dbgGnt    <= 1'b0;
            haltCause <= CAUSE_NONE;
            slowCnt   <= '0;
            bpSkip    <= 1'b0;
            startQ    <= 1'b0;
            modeQ     <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= stateD;
            retState  <= retStateD;
            cpuClk    <= cpuClkD;
            cpuTick   <= cpuTickD;
            dbgGnt    <= dbgGntD;
            haltCause <= haltCauseD;
            slowCnt   <= slowCntD;
            bpSkip    <= bpSkipD;
            startQ    <= startToggle;
            modeQ     <= clkMode;
        end
    end

endmodule

// File: tb/tb_mu0_run_ctrl.sv
// Self-checking bench for mu0_run_ctrl. Expected waveforms come from the
// timing rules: a free run started at cycle 0 with half-period h rises first
// at cycle 1+h and then every 2h cycles.
module tb_mu0_run_ctrl;

    localparam int SLOW_DIV = 3;
    localparam int ADDR_W   = 16;

    logic              clk = 1'b0;
    logic              rstN;
    logic [3:0]        clkMode;
    logic              startToggle;
    logic              stepReq;
    logic              done;
    logic [ADDR_W-1:0] pc;
    logic              bpEn;
    logic [ADDR_W-1:0] bpAddr;
    logic              dbgReq;
    logic              dbgGnt;
    logic              cpuClk;
    logic              cpuTick;
    logic              running;
    logic [1:0]        haltCause;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    mu0_run_ctrl #(.SLOW_DIV(SLOW_DIV), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstN(rstN), .clkMode(clkMode), .startToggle(startToggle),
        .stepReq(stepReq), .done(done), .pc(pc), .bpEn(bpEn), .bpAddr(bpAddr),
        .dbgReq(dbgReq), .dbgGnt(dbgGnt), .cpuClk(cpuClk), .cpuTick(cpuTick),
        .running(running), .haltCause(haltCause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Outputs are sampled at the falling edge, then inputs for that cycle are driven.
    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic expClk(int t, int h, bit off);
        if (off || t < 1 + h) return 1'b0;
        return (((t - 1 - h) / h) % 2) == 0;
    endfunction

    function automatic logic expTick(int t, int h, bit off);
        if (off || t < 1 + h) return 1'b0;
        return ((t - 1 - h) % (2 * h)) == 0;
    endfunction

    task automatic checkAllZero(input string tag);
        check({tag, ".cpuClk"}, cpuClk, 0);
        check({tag, ".cpuTick"}, cpuTick, 0);
        check({tag, ".running"}, running, 0);
        check({tag, ".dbgGnt"}, dbgGnt, 0);
        check({tag, ".haltCause"}, haltCause, 0);
    endtask

    // Free run in a given mode for len cycles, then halt with done.
    task automatic runFree(input logic [3:0] mode, input int len);
        int h;
        bit off;
        off = !(mode == 4'd1 || mode == 4'd2);
        h   = (mode == 4'd2) ? SLOW_DIV + 1 : 1;
        clkMode = mode;
        cyc();
        cyc();
        startToggle = ~startToggle;
        for (int t = 1; t <= len; t++) begin
            cyc();
            check("run.running", running, 1);
            check("run.cpuClk", cpuClk, expClk(t, h, off));
            check("run.cpuTick", cpuTick, expTick(t, h, off));
            if (t == 1) check("run.haltCause", haltCause, 0);
            pc = ADDR_W'($urandom);
        end
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("done.running", running, 0);
        check("done.cpuClk", cpuClk, 0);
        check("done.cpuTick", cpuTick, 0);
        check("done.haltCause", haltCause, 1);
    endtask

    initial begin
        logic [3:0] modes [4];
        int g;
        modes[0] = 4'd1; modes[1] = 4'd2; modes[2] = 4'd0; modes[3] = 4'd9;

        rstN = 1'b0; clkMode = 4'd0; startToggle = 1'b0; stepReq = 1'b0; done = 1'b0;
        pc = '0; bpEn = 1'b0; bpAddr = '0; dbgReq = 1'b0;
        cyc();
        cyc();
        checkAllZero("reset");
        rstN = 1'b1;

        // Fast run with done at N+7, then a slow run covering several periods.
        runFree(4'd1, 7);
        runFree(4'd2, 4 * 2 * (SLOW_DIV + 1) + 3);
        repeat (8) runFree(modes[$urandom_range(0, 3)], $urandom_range(4, 30));

        // Breakpoint: halt on a rise with no tick, then one skipped rise after restart.
        clkMode = 4'd1;
        bpEn    = 1'b1;
        bpAddr  = ADDR_W'($urandom_range(1, 16'hFFFE));
        pc      = bpAddr ^ 16'h1;
        cyc();
        startToggle = ~startToggle;
        for (int t = 1; t <= 4; t++) begin
            cyc();
            check("bp.pre.cpuClk", cpuClk, expClk(t, 1, 0));
            check("bp.pre.cpuTick", cpuTick, expTick(t, 1, 0));
        end
        pc = bpAddr;
        cyc();
        check("bp.t5.running", running, 1);
        check("bp.t5.cpuClk", cpuClk, 0);
        cyc();
        check("bp.halt.running", running, 0);
        check("bp.halt.cause", haltCause, 2);
        check("bp.halt.cpuTick", cpuTick, 0);
        check("bp.halt.cpuClk", cpuClk, 0);
        repeat (3) begin
            cyc();
            check("bp.idle.cpuTick", cpuTick, 0);
        end
        startToggle = ~startToggle;
        cyc();
        check("bp.re.running", running, 1);
        check("bp.re.cause", haltCause, 0);
        cyc();
        check("bp.re.cpuTick", cpuTick, 1);
        check("bp.re.cpuClk", cpuClk, 1);
        cyc();
        check("bp.re.fall", cpuClk, 0);
        cyc();
        check("bp.re2.running", running, 0);
        check("bp.re2.cause", haltCause, 2);
        check("bp.re2.cpuTick", cpuTick, 0);
        bpEn = 1'b0;

        // Debugger grant while the clock is high, release, then done while granted.
        clkMode = 4'd1;
        cyc();
        startToggle = ~startToggle;
        cyc();
        check("dbg.running", running, 1);
        cyc();
        check("dbg.rise", cpuTick, 1);
        dbgReq = 1'b1;
        cyc();
        check("dbg.force.cpuClk", cpuClk, 0);
        check("dbg.force.gnt", dbgGnt, 0);
        check("dbg.force.cpuTick", cpuTick, 0);
        cyc();
        check("dbg.gnt", dbgGnt, 1);
        check("dbg.gnt.running", running, 0);
        g = $urandom_range(2, 10);
        repeat (g) begin
            cyc();
            check("dbg.hold.cpuTick", cpuTick, 0);
            check("dbg.hold.cpuClk", cpuClk, 0);
            check("dbg.hold.gnt", dbgGnt, 1);
        end
        dbgReq = 1'b0;
        cyc();
        check("dbg.rel.gnt", dbgGnt, 0);
        check("dbg.rel.running", running, 1);
        cyc();
        check("dbg.resume.cpuTick", cpuTick, 1);
        check("dbg.resume.cpuClk", cpuClk, 1);
        cyc();
        check("dbg.resume.fall", cpuClk, 0);
        dbgReq = 1'b1;
        cyc();
        check("dbg.low.gnt", dbgGnt, 1);
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("dbg.done.gnt", dbgGnt, 1);
        check("dbg.done.cause", haltCause, 1);
        dbgReq = 1'b0;
        cyc();
        check("dbg.done.rel.gnt", dbgGnt, 0);
        check("dbg.done.rel.running", running, 0);
        dbgReq = 1'b1;
        cyc();
        check("dbg.halted.gnt", dbgGnt, 1);
        dbgReq = 1'b0;
        cyc();
        check("dbg.halted.rel", dbgGnt, 0);
        check("dbg.halted.running", running, 0);

        // Manual mode 3 -> 4 -> 3 while running, then a single step from HALTED.
        clkMode = 4'd3;
        cyc();
        startToggle = ~startToggle;
        cyc();
        check("man.running", running, 1);
        check("man.low", cpuClk, 0);
        cyc();
        check("man.low2", cpuClk, 0);
        clkMode = 4'd4;
        cyc();
        check("man.high", cpuClk, 1);
        check("man.tick", cpuTick, 1);
        cyc();
        check("man.high2", cpuClk, 1);
        check("man.tick2", cpuTick, 0);
        clkMode = 4'd3;
        cyc();
        check("man.back", cpuClk, 0);
        check("man.back.tick", cpuTick, 0);
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("man.halt", running, 0);
        stepReq = 1'b1;
        cyc();
        stepReq = 1'b0;
        check("step.cpuClk", cpuClk, 1);
        check("step.cpuTick", cpuTick, 1);
        check("step.running", running, 0);
        cyc();
        check("step.fall", cpuClk, 0);
        check("step.tick0", cpuTick, 0);
        repeat (3) begin
            cyc();
            check("step.after.cpuClk", cpuClk, 0);
            check("step.after.running", running, 0);
            check("step.after.cause", haltCause, 1);
        end

        // Asynchronous reset while the clock is high; a held start level restarts.
        clkMode = 4'd1;
        cyc();
        startToggle = ~startToggle;
        cyc();
        check("rst.running", running, 1);
        startToggle = 1'b1;
        cyc();
        check("rst.high", cpuClk, 1);
        #2 rstN = 1'b0;
        #1 checkAllZero("rst.async");
        cyc();
        checkAllZero("rst.held");
        rstN = 1'b1;
        cyc();
        check("rst.restart.running", running, 1);
        check("rst.restart.cpuClk", cpuClk, 0);
        cyc();
        check("rst.restart.tick", cpuTick, 1);
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("rst.done", running, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mu0_run_ctrl.md
# mu0_run_ctrl

Run controller for the MU0 core. It turns the debugger's start/step/clock-mode commands into a gated core clock level plus a one-cycle tick strobe, and halts the core on `done` or a PC breakpoint. It also arbitrates the shared program memory between the core and the UART debugger. It sits between the UART debug block and the mu0 core, replacing free-running clock-division logic in the top level.

## Interface

Parameters:

- `SLOW_DIV`, 6318000: system cycles per half-period of `cpuClk` in slow mode is `SLOW_DIV+1`.
- `ADDR_W`, 16: PC / breakpoint width.

Ports:

- `clk`  in  1  system clock.
- `rstN`  in  1  asynchronous, active-low reset.
- `clkMode`  in  4  0 off, 1 fast, 2 slow, 3 manual-low, 4 manual-high; any other value is treated as off.
- `startToggle`  in  1  start command; any change of level is one start event.
- `stepReq`  in  1  single-cycle pulse requesting one core clock period.
- `done`  in  1  core halt indication.
- `pc`  in  ADDR_W  core program counter.
- `bpEn`  in  1  breakpoint enable.
- `bpAddr`  in  ADDR_W  breakpoint address.
- `dbgReq`  in  1  debugger memory request (level).
- `dbgGnt`  out  1  debugger owns memory; the core clock is frozen.
- `cpuClk`  out  1  core clock level (registered).
- `cpuTick`  out  1  one-cycle strobe, high in the cycle `cpuClk` first reads 1.
- `running`  out  1  state is RUN.
- `haltCause`  out  2  0 none, 1 done, 2 breakpoint; sticky until the next start.

## Operation

**States:** IDLE, RUN, STEP, HALTED, DBG. A return-state register is used by DBG.

**Reset values:** state IDLE; `cpuClk`, `cpuTick`, `running`, `dbgGnt` all 0; `haltCause` 0; slow counter 0; start edge register 0; `bpSkip` 0.

**Start event** (`startToggle` differs from its registered copy):
- From IDLE or HALTED: go to RUN, clear `haltCause`, set `bpSkip`.
- Ignored in RUN, STEP and DBG; the edge register still updates.

**RUN, priority order per cycle:**
1. `done`=1: go to HALTED, `haltCause`=1, `cpuClk` forced 0, no tick.
2. `dbgReq`=1: freeze the clock (see Arbitration).
3. A rising edge is due, and `bpEn` && `pc==bpAddr` && !`bpSkip`: go to HALTED, `haltCause`=2, no rise.
4. Otherwise apply the mode rule:
   - fast: toggle every cycle.
   - slow: counter increments; when it reaches `SLOW_DIV`, toggle and clear the counter.
   - manual: `cpuClk` follows the level (mode 4 gives 1, mode 3 gives 0).
   - off: `cpuClk` goes to 0.
- Each rise pulses `cpuTick` and clears `bpSkip`.
- A change of `clkMode` clears the slow counter.

**STEP:**
- Entered from IDLE or HALTED on `stepReq`.
- `cpuClk` is 1 for one cycle with `cpuTick`, then 0, then the block returns to the originating state. This ignores `clkMode` and the breakpoint.
- `stepReq` outside IDLE/HALTED is ignored.

**Arbitration:**
- From IDLE or HALTED: `dbgReq` sets `dbgGnt` next cycle.
- From RUN: if `cpuClk`=1, force `cpuClk` 0 next cycle, then grant the following cycle. If `cpuClk`=0, grant next cycle.
- A request arriving during STEP is granted after STEP completes.
- In DBG, `cpuClk` is held 0 and no ticks are issued.
- `dbgReq` low drops `dbgGnt` next cycle, restores the return state and clears the slow counter.
- `done` is still honoured in DBG: the return state becomes HALTED with `haltCause`=1.

## Timing

- Start edge sampled at cycle N: `running`=1 at N+1. In fast mode `cpuClk`=1 and `cpuTick`=1 at N+2, then `cpuClk` toggles every cycle.
- Slow mode: `cpuClk` period is 2·(`SLOW_DIV`+1) cycles.
- `done` sampled at N: HALTED, `running`=0 and `cpuClk`=0 at N+1.
- Breakpoint check uses the `pc` value sampled in the cycle the rise would be issued.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous); no tick is emitted.

## Test plan

- **Fast run.** Reset, `clkMode`=1, toggle `startToggle` at N → `running` at N+1, `cpuTick` at N+2, N+4, N+6; assert `done` at N+7 → `running`=0, `cpuClk`=0 and `haltCause`=1 at N+8.
- **Slow mode.** `SLOW_DIV`=3, `clkMode`=2, start → `cpuClk` period 8 cycles, one `cpuTick` per period.
- **Breakpoint.** `bpEn`=1, `bpAddr`=5, `pc` driven 5 → halt with `haltCause`=2 and no tick. Re-start → exactly one tick is issued despite `pc`=5, then the halt reoccurs on the next rise.
- **Debugger grant.** `dbgReq` raised while `cpuClk`=1 → `cpuClk` 0 next cycle, `dbgGnt` the cycle after, zero ticks while granted. Release → `dbgGnt` 0 next cycle, ticks resume.
- **Manual mode.** `clkMode` 3→4→3 in RUN → `cpuClk` follows one cycle later, exactly one `cpuTick`. In HALTED, `stepReq` → one tick, state stays HALTED.
- **Reset mid-run.** `rstN` low while `cpuClk`=1 → all outputs 0 asynchronously; after release, a `startToggle` already at 1 counts as a start.
